// File: rtl/tile_ctrl_axil_master.sv
// tile_ctrl_axil_master
//   AXI4-Lite initiator for a tile's control_S_AXI port. Takes single-beat register commands
//   from a valid/ready stream, issues one AXI-Lite write or read at a time, and returns the
//   read data, response code and the accept-to-handshake latency on a response stream.
//
// Ports:
//   clk_control, clk_control_rst_high      clock, synchronous active-high reset
//   cmd_valid/ready, cmd_write/addr/wdata/wstrb   command stream (1 = write)
//   rsp_valid/ready, rsp_write/rdata/resp/latency response stream
//   m_AW*, m_W*, m_B*, m_AR*, m_R*          AXI4-Lite master channels
//
// Every m_* output and cmd_ready/rsp_valid is a decode of registered state only, so there is
// no combinational path from any slave input to any master output.
module tile_ctrl_axil_master #(
   parameter int unsigned BW       = 32,
   parameter int unsigned BWB      = BW / 8,
   parameter int unsigned AXI_ADDR = 8,
   parameter int unsigned LAT_W    = 16
) (
   input  logic                clk_control,
   input  logic                clk_control_rst_high,
   // command stream
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [AXI_ADDR-1:0] cmd_addr,
   input  logic [BW-1:0]       cmd_wdata,
   input  logic [BWB-1:0]      cmd_wstrb,
   // response stream
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_write,
   output logic [BW-1:0]       rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic [LAT_W-1:0]    rsp_latency,
   // AXI4-Lite write address
   output logic [AXI_ADDR-1:0] m_AWADDR,
   output logic                m_AWVALID,
   input  logic                m_AWREADY,
   // AXI4-Lite write data
   output logic [BW-1:0]       m_WDATA,
   output logic [BWB-1:0]      m_WSTRB,
   output logic                m_WVALID,
   input  logic                m_WREADY,
   // AXI4-Lite write response
   input  logic [1:0]          m_BRESP,
   input  logic                m_BVALID,
   output logic                m_BREADY,
   // AXI4-Lite read address
   output logic [AXI_ADDR-1:0] m_ARADDR,
   output logic                m_ARVALID,
   input  logic                m_ARREADY,
   // AXI4-Lite read data
   input  logic [BW-1:0]       m_RDATA,
   input  logic [1:0]          m_RRESP,
   input  logic                m_RVALID,
   output logic                m_RREADY
);

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StWrResp,
      StRdAddr,
      StRdData,
      StRsp
   } state_e;

   state_e              state_q, state_d;
   logic                write_q, write_d;
   logic [AXI_ADDR-1:0] addr_q, addr_d;
   logic [BW-1:0]       wdata_q, wdata_d;
   logic [BWB-1:0]      wstrb_q, wstrb_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [BW-1:0]       rdata_q, rdata_d;
   logic [1:0]          resp_q, resp_d;
   logic [LAT_W-1:0]    lat_inc;

   // Saturating increment: holds at all-ones instead of wrapping.
   assign lat_inc = (lat_q == {LAT_W{1'b1}}) ? lat_q : lat_q + LAT_W'(1);

   always_comb begin
      state_d   = state_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      lat_d     = lat_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               write_d   = cmd_write;
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               lat_d     = '0;
               state_d   = cmd_write ? StWr : StRdAddr;
            end
         end
         StWr: begin
            lat_d = lat_inc;
            // A done channel has VALID low, so a late READY on it is harmless.
            aw_done_d = aw_done_q | m_AWREADY;
            w_done_d  = w_done_q | m_WREADY;
            if (aw_done_d && w_done_d) begin
               state_d = StWrResp;
            end
         end
         StWrResp: begin
            lat_d = lat_inc;
            if (m_BVALID) begin
               resp_d  = m_BRESP;
               rdata_d = '0;
               state_d = StRsp;
            end
         end
         StRdAddr: begin
            lat_d = lat_inc;
            if (m_ARREADY) begin
               state_d = StRdData;
            end
         end
         StRdData: begin
            lat_d = lat_inc;
            if (m_RVALID) begin
               resp_d  = m_RRESP;
               rdata_d = m_RDATA;
               state_d = StRsp;
            end
         end
         StRsp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_control) begin
      if (clk_control_rst_high) begin
         state_q   <= StIdle;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         lat_q     <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
      end else begin
         state_q   <= state_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         lat_q     <= lat_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
      end
   end

   assign cmd_ready   = (state_q == StIdle);
   assign rsp_valid   = (state_q == StRsp);
   assign rsp_write   = write_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_resp    = resp_q;
   assign rsp_latency = lat_q;

   assign m_AWADDR  = addr_q;
   assign m_AWVALID = (state_q == StWr) && !aw_done_q;
   assign m_WDATA   = wdata_q;
   assign m_WSTRB   = wstrb_q;
   assign m_WVALID  = (state_q == StWr) && !w_done_q;
   assign m_BREADY  = (state_q == StWrResp);
   assign m_ARADDR  = addr_q;
   assign m_ARVALID = (state_q == StRdAddr);
   assign m_RREADY  = (state_q == StRdData);

endmodule

// File: tb/tb_tile_ctrl_axil_master.sv
// Bench for tile_ctrl_axil_master: a scripted AXI-Lite slave driven from per-transaction delay
// parameters, with expected channel activity and latency derived from the transaction timeline.
// A second instance with LAT_W = 4 shares all inputs to exercise latency saturation.
module tb_tile_ctrl_axil_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_ready = 1'b0;
   logic        m_AWREADY = 1'b0, m_WREADY = 1'b0, m_BVALID = 1'b0;
   logic        m_ARREADY = 1'b0, m_RVALID = 1'b0;
   logic [1:0]  m_BRESP = '0, m_RRESP = '0;
   logic [31:0] m_RDATA = '0;

   logic        cmd_ready, rsp_valid, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [15:0] rsp_latency;
   logic [7:0]  m_AWADDR, m_ARADDR;
   logic        m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY;
   logic [31:0] m_WDATA;
   logic [3:0]  m_WSTRB;

   logic        s_cmd_ready, s_rsp_valid, s_rsp_write;
   logic [31:0] s_rsp_rdata;
   logic [1:0]  s_rsp_resp;
   logic [3:0]  s_rsp_latency;
   logic [7:0]  s_AWADDR, s_ARADDR;
   logic        s_AWVALID, s_WVALID, s_BREADY, s_ARVALID, s_RREADY;
   logic [31:0] s_WDATA;
   logic [3:0]  s_WSTRB;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tile_ctrl_axil_master dut (
      .clk_control(clk), .clk_control_rst_high(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
      .m_AWADDR(m_AWADDR), .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
      .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
      .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
      .m_ARADDR(m_ARADDR), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
      .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY)
   );

   tile_ctrl_axil_master #(.LAT_W(4)) dut_sat (
      .clk_control(clk), .clk_control_rst_high(rst),
      .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(s_rsp_write),
      .rsp_rdata(s_rsp_rdata), .rsp_resp(s_rsp_resp), .rsp_latency(s_rsp_latency),
      .m_AWADDR(s_AWADDR), .m_AWVALID(s_AWVALID), .m_AWREADY(m_AWREADY),
      .m_WDATA(s_WDATA), .m_WSTRB(s_WSTRB), .m_WVALID(s_WVALID), .m_WREADY(m_WREADY),
      .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(s_BREADY),
      .m_ARADDR(s_ARADDR), .m_ARVALID(s_ARVALID), .m_ARREADY(m_ARREADY),
      .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RVALID(m_RVALID), .m_RREADY(s_RREADY)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One full command/response exchange. Cycle 0 is the accept cycle; a channel READY/VALID
   // from the slave is pulsed exactly in the cycle its handshake is due.
   task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int aw_d, input int w_d, input int b_d,
                          input int ar_d, input int r_d, input logic [1:0] resp,
                          input logic [31:0] rdata, input int rsp_d);
      int mx, lat, aw_n, w_n, b_n, ar_n, r_n;
      logic [31:0] exp_rdata;
      mx = (aw_d > w_d) ? aw_d : w_d;
      // Write: AW/W done at cycle 1+mx, BREADY from 2+mx, B after b_d more cycles.
      // Read: AR done at 1+ar_d, RREADY from 2+ar_d, R after r_d more cycles.
      lat = wr ? (2 + mx + b_d) : (2 + ar_d + r_d);
      exp_rdata = wr ? 32'h0 : rdata;
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;

      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
      @(negedge clk);
      check_eq("cmd_ready_idle", cmd_ready, 1'b1);
      @(posedge clk); #1;
      // Scramble the command bus: it must be ignored once accepted.
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom);
      cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);

      for (int cyc = 1; cyc <= lat; cyc++) begin
         m_AWREADY = wr && (cyc == 1 + aw_d);
         m_WREADY  = wr && (cyc == 1 + w_d);
         m_BVALID  = wr && (cyc == lat);
         m_BRESP   = m_BVALID ? resp : 2'($urandom);
         m_ARREADY = !wr && (cyc == 1 + ar_d);
         m_RVALID  = !wr && (cyc == lat);
         m_RDATA   = m_RVALID ? rdata : $urandom;
         m_RRESP   = m_RVALID ? resp : 2'($urandom);
         @(negedge clk);
         check_eq("awvalid", m_AWVALID, wr && (cyc <= 1 + aw_d));
         check_eq("wvalid", m_WVALID, wr && (cyc <= 1 + w_d));
         check_eq("bready", m_BREADY, wr && (cyc >= 2 + mx));
         check_eq("arvalid", m_ARVALID, !wr && (cyc <= 1 + ar_d));
         check_eq("rready", m_RREADY, !wr && (cyc >= 2 + ar_d));
         check_eq("cmd_ready_busy", cmd_ready, 1'b0);
         check_eq("rsp_valid_busy", rsp_valid, 1'b0);
         if (m_AWVALID) check_eq("awaddr", m_AWADDR, addr);
         if (m_WVALID) begin
            check_eq("wdata", m_WDATA, wdata);
            check_eq("wstrb", m_WSTRB, wstrb);
         end
         if (m_ARVALID) check_eq("araddr", m_ARADDR, addr);
         aw_n += int'(m_AWVALID && m_AWREADY);
         w_n  += int'(m_WVALID && m_WREADY);
         b_n  += int'(m_BVALID && m_BREADY);
         ar_n += int'(m_ARVALID && m_ARREADY);
         r_n  += int'(m_RVALID && m_RREADY);
         @(posedge clk); #1;
      end
      m_AWREADY = 1'b0; m_WREADY = 1'b0; m_BVALID = 1'b0; m_ARREADY = 1'b0; m_RVALID = 1'b0;
      check_eq("aw_count", aw_n, wr ? 1 : 0);
      check_eq("w_count", w_n, wr ? 1 : 0);
      check_eq("b_count", b_n, wr ? 1 : 0);
      check_eq("ar_count", ar_n, wr ? 0 : 1);
      check_eq("r_count", r_n, wr ? 0 : 1);

      // Hold a new command on the bus while the response waits; it must not be taken.
      cmd_valid = 1'b1;
      for (int k = 0; k <= rsp_d; k++) begin
         rsp_ready = (k == rsp_d);
         @(negedge clk);
         check_eq("rsp_valid", rsp_valid, 1'b1);
         check_eq("cmd_ready_rsp", cmd_ready, 1'b0);
         check_eq("rsp_write", rsp_write, wr);
         check_eq("rsp_rdata", rsp_rdata, exp_rdata);
         check_eq("rsp_resp", rsp_resp, resp);
         check_eq("rsp_latency", rsp_latency, lat);
         check_eq("rsp_latency_sat", s_rsp_latency, (lat > 15) ? 15 : lat);
         check_eq("sat_rsp_valid", s_rsp_valid, 1'b1);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_cmd_ready", cmd_ready, 1'b1);
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_valids", {m_AWVALID, m_WVALID, m_ARVALID}, 3'b000);
      check_eq("rst_readies", {m_BREADY, m_RREADY}, 2'b00);
      check_eq("rst_rsp_fields", {rsp_write, rsp_rdata, rsp_resp, rsp_latency}, '0);
      @(posedge clk); #1;

      // Zero-wait write.
      run_txn(1'b1, 8'h04, 32'h1, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
      // Read with ARREADY held off 3 cycles.
      run_txn(1'b0, 8'h08, 32'h0, 4'h0, 0, 0, 0, 3, 1, 2'b00, 32'hDEADBEEF, 0);
      // AW accepted 4 cycles before W.
      run_txn(1'b1, 8'h10, 32'hA5A5_0F0F, 4'h3, 0, 4, 1, 0, 0, 2'b00, 32'h0, 0);
      // W before AW.
      run_txn(1'b1, 8'h14, 32'h1234_5678, 4'hC, 3, 1, 0, 0, 0, 2'b00, 32'h0, 1);
      // Error responses pass through, no retry.
      run_txn(1'b1, 8'h20, 32'hCAFE_F00D, 4'hF, 1, 1, 2, 0, 0, 2'b10, 32'h0, 0);
      run_txn(1'b0, 8'h24, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b11, 32'h0BAD_0BAD, 0);
      // Response back-pressure with a command waiting.
      run_txn(1'b1, 8'h30, 32'h5555_AAAA, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 5);
      // Long read: saturates the 4-bit latency counter.
      run_txn(1'b0, 8'h40, 32'h0, 4'h0, 0, 0, 0, 0, 20, 2'b01, 32'h7777_1111, 0);

      // Reset in the middle of a write with the slave stalling both channels.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h50;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check_eq("midwr_awvalid", m_AWVALID, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_valids", {m_AWVALID, m_WVALID, m_ARVALID, rsp_valid}, 4'b0000);
      check_eq("midrst_readies", {m_BREADY, m_RREADY}, 2'b00);
      check_eq("midrst_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) begin
         logic wr;
         int rd;
         wr = 1'($urandom);
         rd = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 20))
                                          : int'($urandom_range(0, 3));
         run_txn(wr, 8'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), rd, 2'($urandom), $urandom,
                 int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
